// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared types and helpers for the multi-cycle shift sequencer
package shift_seq_pkg;
  typedef enum logic [1:0] {SH_LOG, SH_ARI, SH_ROT, SH_RC} shift_type_e;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  function automatic int maxstep(int sw);
    return (1 << sw) - 1;
  endfunction
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational pass applying `size` iterations of the 1-bit shift/rotate op
import shift_seq_pkg::*;
module shift_step #(
  parameter int word_width = 8,
  parameter int step_width = 3
) (
  input  logic                  dir,
  input  shift_type_e           op,
  input  logic [step_width-1:0] size,
  input  logic [word_width-1:0] d_i,
  input  logic                  c_i,
  output logic [word_width-1:0] d_o,
  output logic                  c_o
);
  localparam int MAX = maxstep(step_width);
  logic [word_width-1:0] d;
  logic c, nc;
  always_comb begin
    d = d_i;
    c = c_i;
    nc = 1'b0;
    for (int i = 0; i < MAX; i++)
      if (i < int'(size)) begin
        nc = dir ? d[0] : d[word_width-1];
        d = dir ? {op == SH_ROT ? d[0] : op == SH_RC ? c : op == SH_ARI ? d[word_width-1] : 1'b0, d[word_width-1:1]}
                : {d[word_width-2:0], op == SH_ROT ? d[word_width-1] : op == SH_RC ? c : 1'b0};
        c = nc;
      end
  end
  assign d_o = d;
  assign c_o = c;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift/rotate controller, up to MAXSTEP positions per clock.
// Define SHIFT_SEQ_REDUCE_EN to reduce the amount at accept (same results, shorter latency).
import shift_seq_pkg::*;
module shift_sequencer #(
  parameter int word_width   = 8,
  parameter int step_width   = 3,
  parameter int amount_width = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic                    dir,
  input  logic [1:0]              shift_type,
  input  logic [amount_width-1:0] amount,
  input  logic [word_width-1:0]   D_IN,
  input  logic                    C_IN,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [word_width-1:0]   D_OUT,
  output logic                    C_OUT,
  output logic                    busy
);
  localparam int MAX = maxstep(step_width);
  localparam logic [amount_width-1:0] MAXA = amount_width'(MAX);
  state_e state;
  logic idle, dir_r, dir_s, c_s, c_n;
  shift_type_e op_r, op_in, op_s;
  logic [amount_width-1:0] rem, amt_eff, rem_s, rem_n;
  logic [step_width-1:0] step;
  logic [word_width-1:0] d_s, d_n;
  assign idle = state == S_IDLE;
  assign op_in = shift_type_e'(shift_type);
`ifdef SHIFT_SEQ_REDUCE_EN
  localparam logic [amount_width-1:0] ONE = amount_width'(1);
  localparam logic [amount_width-1:0] WA  = amount_width'(word_width);
  localparam logic [amount_width-1:0] WA1 = amount_width'(word_width + 1);
  // rotate keeps a nonzero multiple of W nonzero so C still reports the last wrapped bit
  always_comb
    amt_eff = op_in == SH_RC  ? amount % WA1 :
              op_in == SH_ROT ? (amount == '0 ? '0 : (amount - ONE) % WA + ONE) :
              amount > WA1    ? WA1 : amount;
`else
  assign amt_eff = amount;
`endif
  // the accept edge already performs the first pass, straight from the inputs
  assign rem_s = idle ? amt_eff : rem;
  assign dir_s = idle ? dir : dir_r;
  assign op_s  = idle ? op_in : op_r;
  assign d_s   = idle ? D_IN : D_OUT;
  assign c_s   = idle ? C_IN : C_OUT;
  assign step  = rem_s > MAXA ? step_width'(MAX) : rem_s[step_width-1:0];
  assign rem_n = rem_s - amount_width'(step);
  shift_step #(.word_width(word_width), .step_width(step_width)) u_step (
    .dir(dir_s), .op(op_s), .size(step), .d_i(d_s), .c_i(c_s), .d_o(d_n), .c_o(c_n)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      rem   <= '0;
      D_OUT <= '0;
      C_OUT <= 1'b0;
      dir_r <= 1'b0;
      op_r  <= SH_LOG;
    end else begin
      if ((idle && start_valid) || state == S_SHIFT) begin
        D_OUT <= d_n;
        C_OUT <= c_n;
        rem   <= rem_n;
        state <= rem_n == '0 ? S_DONE : S_SHIFT;
      end
      if (idle && start_valid) begin
        dir_r <= dir;
        op_r  <= op_in;
      end
      if (state == S_DONE && res_ready) state <= S_IDLE;
    end
  assign start_ready = idle && !rst;
  assign res_valid   = state == S_DONE;
  assign busy        = !idle;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: scoreboard bench with directed vectors for shift_sequencer
module tb_shift_sequencer;
  logic clk = 0, rst = 1, start_valid = 0, dir = 0, C_IN = 0, res_ready = 1;
  logic [1:0] shift_type = 0;
  logic [7:0] amount = 0, D_IN = 0;
  logic start_ready, res_valid, C_OUT, busy;
  logic [7:0] D_OUT;
  shift_sequencer #(.word_width(8), .step_width(3), .amount_width(8)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready), .dir(dir),
    .shift_type(shift_type), .amount(amount), .D_IN(D_IN), .C_IN(C_IN), .res_valid(res_valid),
    .res_ready(res_ready), .D_OUT(D_OUT), .C_OUT(C_OUT), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [7:0] d;
    logic c;
    int lat;
    int acc;
    string name;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  bit have = 0;
  int errors = 0, checks = 0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst) have = 0;
    else if (res_valid) begin
      if (!have) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got D_OUT=%0h expected no result", D_OUT);
        end else begin
          cur = q.pop_front();
          have = 1;
          chk({cur.name, "_latency"}, cyc - cur.acc + 1, cur.lat);
        end
      end
      if (have) begin
        chk({cur.name, "_D_OUT"}, D_OUT, cur.d);
        chk({cur.name, "_C_OUT"}, C_OUT, cur.c);
        chk({cur.name, "_start_ready"}, start_ready, 0);
      end
      if (res_ready) have = 0;
    end
  task automatic run(string n, bit dr, logic [1:0] ty, logic [7:0] am, logic [7:0] d, bit c,
                     logic [7:0] ed, bit ec, int lat_raw, int lat_red);
    exp_t e;
    int t = 0;
    dir = dr; shift_type = ty; amount = am; D_IN = d; C_IN = c; start_valid = 1;
    while (!start_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!start_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got start_ready=0 expected 1 within 200 cycles", n);
      start_valid = 0;
      return;
    end
    e.d = ed; e.c = ec; e.lat = lat_raw; e.acc = cyc + 1; e.name = n;
`ifdef SHIFT_SEQ_REDUCE_EN
    e.lat = lat_red;
`endif
    q.push_back(e);
    @(posedge clk); #1;
    start_valid = 0;
  endtask
  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || have || busy) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask
  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_D_OUT", D_OUT, 0);
    chk("rst_C_OUT", C_OUT, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start_ready", start_ready, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("idle_start_ready", start_ready, 1);
    run("t1_lsl3",   0, 2'b00, 3,  8'hB4, 0, 8'hA0, 1, 1, 1);
    run("t2_amt0",   0, 2'b00, 0,  8'h5A, 1, 8'h5A, 1, 1, 1);
    run("t3_asr10",  1, 2'b01, 10, 8'h81, 0, 8'hFF, 1, 2, 2);
    run("t4_rol9",   0, 2'b10, 9,  8'h81, 0, 8'h03, 1, 2, 1);
    run("t5_rrc1",   1, 2'b11, 1,  8'h01, 0, 8'h00, 1, 1, 1);
    run("t5_rrc9",   1, 2'b11, 9,  8'h01, 0, 8'h01, 0, 2, 1);
    run("lsr7",      1, 2'b00, 7,  8'hF0, 0, 8'h01, 1, 1, 1);
    run("lsr8",      1, 2'b00, 8,  8'hF0, 0, 8'h00, 1, 2, 2);
    run("rol8",      0, 2'b10, 8,  8'hA5, 0, 8'hA5, 1, 2, 2);
    run("asl20",     0, 2'b01, 20, 8'hFF, 1, 8'h00, 0, 3, 2);
    run("ror3",      1, 2'b10, 3,  8'h01, 1, 8'h20, 0, 1, 1);
    run("lrc1",      0, 2'b11, 1,  8'h80, 0, 8'h00, 1, 1, 1);
    drain();
    res_ready = 0;
    run("t6_stall",  0, 2'b00, 1,  8'h3C, 1, 8'h78, 0, 1, 1);
    t = 0;
    while (!res_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("t6_held_valid", res_valid, 1);
    res_ready = 1;
    drain();
    run("t6_rst200", 0, 2'b00, 200, 8'hFF, 0, 8'h00, 0, 29, 2);
    chk("t6_busy_before_rst", busy, 1);
    rst = 1;
    #1;
    chk("t6_rst_res_valid", res_valid, 0);
    chk("t6_rst_D_OUT", D_OUT, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_start_ready", start_ready, 0);
    q.delete();
    @(posedge clk); #1;
    rst = 0;
    repeat (60) @(posedge clk);
    #1;
    chk("t6_post_rst_busy", busy, 0);
    run("post_rst_lsl3", 0, 2'b00, 3, 8'hB4, 0, 8'hA0, 1, 1, 1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
